add_sub_sequencer: RTL

Multi-cycle controller that performs a WIDTH-bit add or subtract by time-sharing one external combinational four-bit adder/subtractor.
- External unit computes A + (B xor {4{subtract}}) + subtract and returns Result and Cout; it has no carry-in.
- This block drives the unit one nibble at a time, LSB first, and inserts correction passes to propagate carry/borrow.
- Operands arrive and results leave on valid/ready handshakes.

---
 rtl/add_sub_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/add_sub_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one external 4-bit adder/subtractor,
// walking nibbles LSB first and inserting a correction pass wherever carry/borrow must ripple in.
module add_sub_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_result,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic [3:0]             au_a,
    output logic [3:0]             au_b,
    output logic                   au_sub,
    input  logic [3:0]             au_result,
    input  logic                   au_cout
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned KW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic             c1_q, c1_d;

    logic             in_ready_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_result_d;
    logic             out_cout_d;
    logic             out_ovf_d;
    logic [3:0]       au_a_d;
    logic [3:0]       au_b_d;
    logic             au_sub_d;

    logic             fix;
    logic             last;
    logic [KW-1:0]    k_nxt;
    logic             adv;
    logic             c_new;
    logic [WIDTH-1:0] res_new;
    logic             sign_a, sign_b, sign_s;

    // A carry (add) or borrow (sub) entering nibble k needs a second pass through the unit
    assign fix   = (k_q != '0) && (c_q ^ op_q);
    assign last  = (k_q == K_LAST);
    assign k_nxt = k_q + KW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (in_valid) state_d = CALC;
            CALC: begin
                if (fix)       state_d = FIX;
                else if (last) state_d = DONE;
                else           state_d = CALC;
            end
            FIX:  state_d = last ? DONE : CALC;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; au_* are prepared for the state being entered
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        op_d         = op_q;
        k_d          = k_q;
        c_d          = c_q;
        c1_d         = c1_q;
        out_valid_d  = out_valid;
        out_result_d = out_result;
        out_cout_d   = out_cout;
        out_ovf_d    = out_ovf;
        au_a_d       = 4'h0;
        au_b_d       = 4'h0;
        au_sub_d     = 1'b0;
        in_ready_d   = (state_d == IDLE);
        adv          = 1'b0;
        c_new        = au_cout;
        res_new      = res_q;
        sign_a       = a_q[WIDTH-1];
        sign_b       = b_q[WIDTH-1];
        sign_s       = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    op_d     = in_sub;
                    k_d      = '0;
                    c_d      = 1'b0;
                    au_a_d   = in_a[3:0];
                    au_b_d   = in_b[3:0];
                    au_sub_d = in_sub;
                end
            end
            CALC: begin
                c1_d = au_cout;
                if (fix) begin
                    au_a_d   = au_result;
                    au_b_d   = 4'b0001;
                    au_sub_d = op_q;
                end else begin
                    adv = 1'b1;
                end
            end
            FIX: begin
                adv   = 1'b1;
                c_new = op_q ? (c1_q & au_cout) : (c1_q | au_cout);
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase

        if (adv) begin
            res_new[{k_q, 2'b00} +: 4] = au_result;
            res_d  = res_new;
            c_d    = c_new;
            sign_s = res_new[WIDTH-1];
            if (last) begin
                out_valid_d  = 1'b1;
                out_result_d = res_new;
                out_cout_d   = c_new;
                out_ovf_d    = op_q ? ((sign_a != sign_b) && (sign_s != sign_a))
                                    : ((sign_a == sign_b) && (sign_s != sign_a));
            end else begin
                k_d      = k_nxt;
                au_a_d   = a_q[{k_nxt, 2'b00} +: 4];
                au_b_d   = b_q[{k_nxt, 2'b00} +: 4];
                au_sub_d = op_q;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            op_q       <= 1'b0;
            k_q        <= '0;
            c_q        <= 1'b0;
            c1_q       <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            au_a       <= 4'h0;
            au_b       <= 4'h0;
            au_sub     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            op_q       <= op_d;
            k_q        <= k_d;
            c_q        <= c_d;
            c1_q       <= c1_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_result <= out_result_d;
            out_cout   <= out_cout_d;
            out_ovf    <= out_ovf_d;
            au_a       <= au_a_d;
            au_b       <= au_b_d;
            au_sub     <= au_sub_d;
        end
    end

endmodule
